// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of a single-ported
// 64K x 32 data memory. Port 0 is the CPU load/store unit and port 1 is the
// debug/loader port. The arbiter issues one memory access per ACCESS cycle,
// registers the read data and returns a one-cycle ack to the owning port.
//
// Request/ack handshake, identical on both ports:
//   A port raises req together with a stable addr/we/wdata/lock and keeps
//   all of them unchanged until it sees its ack. The ack is a single-cycle
//   pulse in the cycle after the memory access. The access is complete in
//   that cycle, and rdata is valid for reads. In the ack cycle the port may
//   present the next access with req held high, or drop req. The port must
//   not drop a request before its ack arrives. If it does, the access still
//   completes and is still acknowledged. rdata holds its value until the
//   next read ack to the same port.
//
// Arbitration: a single requester wins. On a tie, rr_next wins, and rr_next
// then points at the other port. At the end of an ACCESS cycle the owner
// keeps the memory only when it holds both lock and req and has used fewer
// than LOCK_MAX consecutive grants. Otherwise a waiting non-owner takes the
// next cycle, or the arbiter returns to IDLE. An owner holding req without
// lock is not re-granted straight away. It competes again from IDLE.

module dmem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic              p0_lock,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic              p1_lock,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_read_data,

    output logic              busy,

    // Observation of internal state: dbg_state 0 = IDLE, 1 = ACCESS
    output logic              dbg_state,
    output logic              dbg_owner,
    output logic [7:0]        dbg_lock_cnt
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Last lock_cnt value that still allows another locked grant.
    // With LOCK_MAX = 1 the limit is 0, so lock never extends ownership.
    localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX - 1);

    state_t     state;
    state_t     state_nxt;
    logic       owner;
    logic       owner_nxt;
    logic       rr_next;
    logic       rr_next_nxt;
    logic [7:0] lock_cnt;
    logic [7:0] lock_cnt_nxt;

    logic [1:0] req;
    logic [1:0] lock;
    logic       own_req;
    logic       own_lock;
    logic       other_req;
    logic       idle_winner;

    assign req  = {p1_req, p0_req};
    assign lock = {p1_lock, p0_lock};

    // Pick the winner among the current requesters; rr_next breaks a tie.
    function automatic logic pick_winner(input logic [1:0] r, input logic pref);
        logic w;
        if (r[0] && r[1]) begin
            w = pref;
        end else if (r[1]) begin
            w = 1'b1;
        end else begin
            w = 1'b0;
        end
        return w;
    endfunction

    // Request and lock view from the current owner's perspective.
    always_comb begin
        own_req     = req[owner];
        own_lock    = lock[owner];
        other_req   = req[~owner];
        idle_winner = pick_winner(req, rr_next);
    end

    // State register together with owner, round-robin pointer and lock counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= 1'b0;
            rr_next  <= 1'b0;
            lock_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_next  <= rr_next_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    // Next-state decision: grant from IDLE, or choose the next owner at the end of ACCESS.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        rr_next_nxt  = rr_next;
        lock_cnt_nxt = lock_cnt;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt    = ACCESS;
                    owner_nxt    = idle_winner;
                    rr_next_nxt  = ~idle_winner;
                    lock_cnt_nxt = 8'd0;
                end
            end
            ACCESS: begin
                if (own_lock && own_req && (lock_cnt < LOCK_LIMIT)) begin
                    // Locked owner keeps the memory; the waiting port is held off.
                    state_nxt    = ACCESS;
                    rr_next_nxt  = ~owner;
                    lock_cnt_nxt = lock_cnt + 8'd1;
                end else if (other_req) begin
                    // Hand over directly, so alternating ports get one access per cycle.
                    state_nxt    = ACCESS;
                    owner_nxt    = ~owner;
                    rr_next_nxt  = owner;
                    lock_cnt_nxt = 8'd0;
                end else begin
                    state_nxt    = IDLE;
                    lock_cnt_nxt = 8'd0;
                end
            end
            default: begin
                state_nxt    = IDLE;
                lock_cnt_nxt = 8'd0;
            end
        endcase
    end

    // Memory port drive: the owner's request during ACCESS, all zero otherwise.
    always_comb begin
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        if (state == ACCESS) begin
            if (owner) begin
                mem_address      = p1_addr;
                mem_write_data   = p1_wdata;
                mem_write_enable = p1_we;
            end else begin
                mem_address      = p0_addr;
                mem_write_data   = p0_wdata;
                mem_write_enable = p0_we;
            end
        end
    end

    // Completion: pulse the owner's ack and capture read data at the end of ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else begin
            p0_ack <= (state == ACCESS) && !owner;
            p1_ack <= (state == ACCESS) && owner;
            if ((state == ACCESS) && !owner && !p0_we) begin
                p0_rdata <= mem_read_data;
            end
            if ((state == ACCESS) && owner && !p1_we) begin
                p1_rdata <= mem_read_data;
            end
        end
    end

    assign busy         = (state == ACCESS);
    assign dbg_state    = (state == ACCESS);
    assign dbg_owner    = owner;
    assign dbg_lock_cnt = lock_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter. A behavioural memory sits on the memory port.
// Drivers issue transactions and push them into per-port expected queues.
// A monitor pops a transaction on every ack and checks it against a
// transaction-level reference memory, which is updated in ack order.
module tb_dmem_arbiter;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;
    localparam int LOCK_MAX = 8;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                issue_cyc;
    } txn_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // ---------------- DUT signals ----------------
    logic              p0_req = 1'b0, p0_we = 1'b0, p0_lock = 1'b0;
    logic [ADDR_W-1:0] p0_addr = '0;
    logic [DATA_W-1:0] p0_wdata = '0;
    logic              p1_req = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
    logic [ADDR_W-1:0] p1_addr = '0;
    logic [DATA_W-1:0] p1_wdata = '0;
    logic              p0_ack, p1_ack;
    logic [DATA_W-1:0] p0_rdata, p1_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_enable;
    logic [DATA_W-1:0] mem_read_data;
    logic              busy;
    logic              dbg_state;
    logic              dbg_owner;
    logic [7:0]        dbg_lock_cnt;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data),
        .busy(busy), .dbg_state(dbg_state), .dbg_owner(dbg_owner),
        .dbg_lock_cnt(dbg_lock_cnt)
    );

    // ---------------- memory model (combinational read, posedge write) ----------------
    logic [DATA_W-1:0] mem [0:65535];
    logic              bd_we = 1'b0;
    logic [ADDR_W-1:0] bd_addr = '0;
    logic [DATA_W-1:0] bd_data = '0;

    assign mem_read_data = mem[mem_address];
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_write_enable) mem[mem_address] <= mem_write_data;
    end

    // ---------------- scoreboard state ----------------
    logic [DATA_W-1:0] ref_mem [0:65535];
    logic [DATA_W-1:0] last_rdata [2];
    int                last_lat [2];
    txn_t              exp_q0[$];
    txn_t              exp_q1[$];
    int                n_cmp = 0;
    int                n_err = 0;
    bit                mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic issue(input int p, input logic we, input logic lk,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input bit track);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d; t.issue_cyc = cycle;
        if (p == 0) begin
            p0_req = 1'b1; p0_we = we; p0_lock = lk; p0_addr = a; p0_wdata = d;
            if (track) exp_q0.push_back(t);
        end else begin
            p1_req = 1'b1; p1_we = we; p1_lock = lk; p1_addr = a; p1_wdata = d;
            if (track) exp_q1.push_back(t);
        end
    endtask

    task automatic drop(input int p);
        if (p == 0) begin p0_req = 1'b0; p0_lock = 1'b0; end
        else begin p1_req = 1'b0; p1_lock = 1'b0; end
    endtask

    task automatic wait_ack(input int p, input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((p == 0 && p0_ack) || (p == 1 && p1_ack)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL ack_timeout_p%0d: no ack within %0d cycles, required an ack", p, budget);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        mon_en = 1'b0;
        rst_n = 1'b0;
        drop(0); drop(1);
        #1;
        check("rst_acks", 64'({p0_ack, p1_ack}), 64'(0));
        check("rst_rdata", 64'({p0_rdata, p1_rdata}), 64'(0));
        check("rst_mem_port", 64'({mem_write_enable, mem_address, mem_write_data}), 64'(0));
        check("rst_state", 64'({busy, dbg_state, dbg_owner, dbg_lock_cnt}), 64'(0));
        exp_q0.delete(); exp_q1.delete();
        last_rdata[0] = '0; last_rdata[1] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic score(input int p);
        txn_t t;
        logic [DATA_W-1:0] rd;
        int lat;
        bit empty;
        rd = (p == 0) ? p0_rdata : p1_rdata;
        empty = (p == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
        if (empty) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_ack_p%0d: ack=1 with nothing outstanding, required ack=0 (t=%0t)", p, $time);
            return;
        end
        if (p == 0) t = exp_q0.pop_front();
        else        t = exp_q1.pop_front();
        if (t.we) ref_mem[t.addr] = t.wdata;
        else      last_rdata[p] = ref_mem[t.addr];
        check($sformatf("p%0d_rdata", p), 64'(rd), 64'(last_rdata[p]));
        lat = cycle - t.issue_cyc - 1;
        last_lat[p] = lat;
        n_cmp++;
        if (lat > LOCK_MAX + 1) begin
            n_err++;
            $display("FAIL p%0d_wait: waited %0d cycles, required <= %0d", p, lat, LOCK_MAX + 1);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (!busy) check("idle_mem_port", 64'({mem_write_enable, mem_address, mem_write_data}), 64'(0));
            if (p0_ack) score(0);
            if (p1_ack) score(1);
        end
    end

    // ---------------- random driver ----------------
    task automatic drive_random(input int p, input int n);
        bit   prev_lock;
        bit   got;
        logic lk;
        int   gap;
        prev_lock = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!prev_lock) begin
                gap = $urandom_range(0, 3);
                if (gap != 0) begin
                    drop(p);
                    repeat (gap) @(negedge clk);
                end
            end
            // A held lock must be followed by another request, so the last one never locks.
            lk = (i != n - 1) && ($urandom_range(0, 2) == 0);
            issue(p, 1'($urandom_range(0, 1)), lk, 16'($urandom_range(0, 63)), $urandom, 1'b1);
            wait_ack(p, 4 * LOCK_MAX, got);
            prev_lock = lk;
        end
        drop(p);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit got;
        int n0;
        int n0_before;
        bit seen1;

        do_reset();
        for (int a = 0; a < 512; a++) poke(16'(a), $urandom);

        // T1: single read
        poke(16'h0010, 32'hDEADBEEF);
        issue(0, 1'b0, 1'b0, 16'h0010, 32'h0, 1'b1);
        @(negedge clk);
        check("t1_busy", 64'(busy), 64'(1));
        check("t1_early_ack", 64'(p0_ack), 64'(0));
        @(negedge clk);
        check("t1_acks", 64'({p0_ack, p1_ack}), 64'(2'b10));
        drop(0);
        #1;
        check("t1_rdata", 64'(p0_rdata), 64'(32'hDEADBEEF));
        check("t1_latency", 64'(last_lat[0]), 64'(1));
        @(negedge clk);
        check("t1_ack_pulse", 64'(p0_ack), 64'(0));

        // T2: tie straight after reset goes to port 0 first
        do_reset();
        issue(0, 1'b0, 1'b0, 16'h0001, 32'h0, 1'b1);
        issue(1, 1'b0, 1'b0, 16'h0002, 32'h0, 1'b1);
        @(negedge clk);
        check("t2_c1", 64'({busy, p0_ack, p1_ack}), 64'(3'b100));
        @(negedge clk);
        check("t2_c2", 64'({busy, p0_ack, p1_ack}), 64'(3'b110));
        drop(0);
        @(negedge clk);
        check("t2_c3", 64'({busy, p0_ack, p1_ack}), 64'(3'b001));
        drop(1);
        repeat (2) @(negedge clk);

        // T3: bounded lock
        issue(0, 1'b0, 1'b1, 16'h0100, 32'h0, 1'b1);
        issue(1, 1'b0, 1'b0, 16'h0180, 32'h0, 1'b1);
        n0 = 0; n0_before = -1; seen1 = 1'b0;
        for (int i = 0; i < 30 && !seen1; i++) begin
            @(negedge clk);
            if (p1_ack) begin seen1 = 1'b1; n0_before = n0; end
            if (p0_ack) begin
                n0++;
                if (n0 < LOCK_MAX) issue(0, 1'b0, 1'b1, 16'(16'h0100 + n0), 32'h0, 1'b1);
                else drop(0);
            end
        end
        drop(1);
        #1;
        check("t3_p1_acked", 64'(seen1), 64'(1));
        check("t3_locked_grants", 64'(n0_before), 64'(LOCK_MAX));
        check("t3_p1_wait_bound", 64'(last_lat[1] <= LOCK_MAX + 1), 64'(1));
        repeat (2) @(negedge clk);

        // T4: write on port 1, read back on port 0
        issue(1, 1'b1, 1'b0, 16'h1234, 32'hCAFEF00D, 1'b1);
        wait_ack(1, 10, got);
        drop(1);
        issue(0, 1'b0, 1'b0, 16'h1234, 32'h0, 1'b1);
        wait_ack(0, 10, got);
        drop(0);
        #1;
        check("t4_p0_rdata", 64'(p0_rdata), 64'(32'hCAFEF00D));
        check("t4_p1_rdata_held", 64'(p1_rdata), 64'(last_rdata[1]));
        @(negedge clk);

        // T5: reset in the middle of a write access
        poke(16'h0020, 32'h11112222);
        issue(0, 1'b1, 1'b0, 16'h0020, 32'h55AA55AA, 1'b0);
        @(negedge clk);
        check("t5_in_access", 64'({busy, mem_write_enable}), 64'(2'b11));
        rst_n = 1'b0;
        drop(0);
        #1;
        check("t5_we_drops", 64'({busy, mem_write_enable, mem_address, mem_write_data}), 64'(0));
        @(negedge clk);
        check("t5_no_ack", 64'({p0_ack, p1_ack}), 64'(0));
        check("t5_mem_kept", 64'(mem[16'h0020]), 64'(32'h11112222));
        last_rdata[0] = '0; last_rdata[1] = '0;
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_rdata_cleared", 64'({p0_rdata, p1_rdata}), 64'(0));

        // T6: random traffic on both ports
        fork
            drive_random(0, 2000);
            drive_random(1, 2000);
        join
        repeat (4) @(negedge clk);
        check("p0_outstanding", 64'(exp_q0.size()), 64'(0));
        check("p1_outstanding", 64'(exp_q1.size()), 64'(0));
        for (int a = 0; a < 64; a++) check($sformatf("mem_%0h", a), 64'(mem[a]), 64'(ref_mem[a]));
        check("mem_1234", 64'(mem[16'h1234]), 64'(ref_mem[16'h1234]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
